// File: rtl/safe_lock_if.sv
// Keypad-side strobes and display-side status of the safe lock controller.
// The keypad scanner is the master; the controller is the slave.
interface safe_lock_if;
    logic       digit_valid;
    logic [3:0] digit;
    logic       enter;
    logic       lock_cmd;
    logic       set_code;
    logic [1:0] status;
    logic       fail_pulse;
    logic [1:0] attempts;

    modport master (
        output digit_valid, digit, enter, lock_cmd, set_code,
        input  status, fail_pulse, attempts
    );

    modport slave (
        input  digit_valid, digit, enter, lock_cmd, set_code,
        output status, fail_pulse, attempts
    );
endinterface

// File: rtl/safe_lock_ctrl.sv
// Safe lock controller: keypad code entry, failed-attempt lockout and in-field
// code change, producing the locked/unlocked/lockout status bus.
module safe_lock_ctrl #(
    parameter int unsigned                CODE_LEN     = 4,
    parameter int unsigned                MAX_TRIES    = 3,
    parameter int unsigned                LOCKOUT_CYC  = 1000,
    parameter logic [CODE_LEN*4-1:0]      DEFAULT_CODE = 16'h1234
) (
    input  logic        clk,
    input  logic        rst_n,
    safe_lock_if.slave  bus
);
    localparam int unsigned BUF_W = CODE_LEN * 4;
    localparam int unsigned CNT_W = $clog2(CODE_LEN + 1);
    localparam int unsigned TMR_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
    localparam logic [1:0]  MAX_T = 2'(MAX_TRIES);

    // State encodings double as the status bus values.
    typedef enum logic [1:0] {
        LOCKED   = 2'b01,
        UNLOCKED = 2'b10,
        LOCKOUT  = 2'b11
    } state_t;

    state_t             state;
    logic [BUF_W-1:0]   code;
    logic [BUF_W-1:0]   buffer;
    logic [CNT_W-1:0]   count;
    logic               overflow;
    logic [1:0]         attempts;
    logic               fail_pulse;
    logic [TMR_W-1:0]   timer;

    logic               count_full;
    logic               entry_ok;
    logic               match;
    logic [1:0]         tries_next;
    logic [BUF_W-1:0]   shifted;

    always_comb begin
        count_full = (count == CNT_W'(CODE_LEN));
        entry_ok   = count_full && !overflow;
        match      = entry_ok && (buffer == code);
        tries_next = (attempts == MAX_T) ? attempts : attempts + 2'd1;
        // Truncating cast keeps the newest CODE_LEN digits, valid even for CODE_LEN=1.
        shifted    = BUF_W'({buffer, bus.digit});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOCKED;
            code       <= DEFAULT_CODE;
            buffer     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            attempts   <= '0;
            fail_pulse <= 1'b0;
            timer      <= '0;
        end else begin
            fail_pulse <= 1'b0;
            case (state)
                LOCKED: begin
                    if (bus.enter) begin
                        buffer   <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                        if (match) begin
                            state    <= UNLOCKED;
                            attempts <= '0;
                        end else begin
                            fail_pulse <= 1'b1;
                            attempts   <= tries_next;
                            if (tries_next == MAX_T) begin
                                state <= LOCKOUT;
                                timer <= TMR_W'(LOCKOUT_CYC - 1);
                            end
                        end
                    end else if (!bus.set_code && !bus.lock_cmd && bus.digit_valid) begin
                        buffer   <= shifted;
                        count    <= count_full ? count : count + 1'b1;
                        overflow <= overflow || count_full || (bus.digit > 4'd9);
                    end
                end
                UNLOCKED: begin
                    if (bus.enter) begin
                        buffer   <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                    end else if (bus.set_code) begin
                        if (entry_ok) code <= buffer;
                        else          fail_pulse <= 1'b1;
                        buffer   <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                    end else if (bus.lock_cmd) begin
                        state    <= LOCKED;
                        buffer   <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                    end else if (bus.digit_valid) begin
                        buffer   <= shifted;
                        count    <= count_full ? count : count + 1'b1;
                        overflow <= overflow || count_full || (bus.digit > 4'd9);
                    end
                end
                LOCKOUT: begin
                    if (timer == '0) begin
                        state    <= LOCKED;
                        attempts <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= LOCKED;
            endcase
        end
    end

    assign bus.status     = state;
    assign bus.fail_pulse = fail_pulse;
    assign bus.attempts   = attempts;
endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Directed bench for safe_lock_ctrl: unlock, lockout timing, malformed entries,
// code change, strobe priority and asynchronous reset.
module tb_safe_lock_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   fails  = 0;
    int   n;

    safe_lock_if bus ();

    safe_lock_ctrl #(
        .CODE_LEN    (4),
        .MAX_TRIES   (3),
        .LOCKOUT_CYC (1000),
        .DEFAULT_CODE(16'h1234)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        bus.digit_valid = 1'b1;
        bus.digit       = d;
        tick();
        bus.digit_valid = 1'b0;
    endtask

    task automatic key4(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
    endtask

    task automatic do_enter();
        bus.enter = 1'b1;
        tick();
        bus.enter = 1'b0;
    endtask

    task automatic do_set();
        bus.set_code = 1'b1;
        tick();
        bus.set_code = 1'b0;
    endtask

    task automatic do_lock();
        bus.lock_cmd = 1'b1;
        tick();
        bus.lock_cmd = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        bus.digit_valid = 1'b0;
        bus.digit       = '0;
        bus.enter       = 1'b0;
        bus.lock_cmd    = 1'b0;
        bus.set_code    = 1'b0;
        #12;
        check("reset_status", 32'(bus.status), 32'h1);
        check("reset_attempts", 32'(bus.attempts), 32'h0);
        check("reset_fail", 32'(bus.fail_pulse), 32'h0);
        rst_n = 1'b1;
        tick();

        // 1: correct code unlocks
        key4(16'h1234);
        check("t1_pre_enter", 32'(bus.status), 32'h1);
        do_enter();
        check("t1_status", 32'(bus.status), 32'h2);
        check("t1_attempts", 32'(bus.attempts), 32'h0);
        check("t1_fail", 32'(bus.fail_pulse), 32'h0);
        do_lock();
        check("t1_relock", 32'(bus.status), 32'h1);

        // 2: three wrong codes trigger lockout
        for (int k = 1; k <= 3; k++) begin
            key4(16'h1235);
            do_enter();
            check("t2_fail", 32'(bus.fail_pulse), 32'h1);
            check("t2_attempts", 32'(k), 32'(bus.attempts));
            check("t2_status", 32'(bus.status), (k < 3) ? 32'h1 : 32'h3);
            if (k == 1) begin
                tick();
                check("t2_pulse_width", 32'(bus.fail_pulse), 32'h0);
            end
        end
        n = 1;
        for (int c = 0; c < 2000 && bus.status == 2'b11; c++) begin
            if (c == 10) begin
                bus.digit_valid = 1'b1;
                bus.digit       = 4'd1;
            end
            if (c == 20) bus.enter = 1'b1;
            if (c == 30) begin
                check("t2_lock_attempts", 32'(bus.attempts), 32'h3);
                check("t2_lock_fail", 32'(bus.fail_pulse), 32'h0);
            end
            tick();
            bus.digit_valid = 1'b0;
            bus.enter       = 1'b0;
            if (bus.status == 2'b11) n++;
        end
        check("t2_lockout_len", 32'(n), 32'd1000);
        check("t2_after_status", 32'(bus.status), 32'h1);
        check("t2_after_attempts", 32'(bus.attempts), 32'h0);
        key4(16'h1234);
        do_enter();
        check("t2_ignored_input", 32'(bus.status), 32'h2);
        do_lock();

        // 3: short and long entries rejected
        press(4'd1); press(4'd2); press(4'd3);
        do_enter();
        check("t3_short_fail", 32'(bus.fail_pulse), 32'h1);
        check("t3_short_attempts", 32'(bus.attempts), 32'h1);
        key4(16'h1234); press(4'd5);
        do_enter();
        check("t3_long_fail", 32'(bus.fail_pulse), 32'h1);
        check("t3_long_attempts", 32'(bus.attempts), 32'h2);
        check("t3_long_status", 32'(bus.status), 32'h1);
        key4(16'h1234);
        do_enter();
        check("t3_unlock", 32'(bus.status), 32'h2);
        check("t3_attempts_clear", 32'(bus.attempts), 32'h0);
        key4(16'h98A6);
        do_set();
        check("t3_nonbcd_set_fail", 32'(bus.fail_pulse), 32'h1);

        // 4: code change
        key4(16'h9876);
        do_set();
        check("t4_set_ok", 32'(bus.fail_pulse), 32'h0);
        check("t4_set_status", 32'(bus.status), 32'h2);
        press(4'd5);
        do_set();
        check("t4_short_set_fail", 32'(bus.fail_pulse), 32'h1);
        press(4'd1);
        do_enter();
        check("t4_enter_unlocked", 32'(bus.status), 32'h2);
        check("t4_enter_unlocked_fail", 32'(bus.fail_pulse), 32'h0);
        do_lock();
        check("t4_locked", 32'(bus.status), 32'h1);
        do_set();
        check("t4_set_in_locked", 32'(bus.fail_pulse), 32'h0);
        do_lock();
        check("t4_lock_in_locked", 32'(bus.fail_pulse), 32'h0);
        key4(16'h1234);
        do_enter();
        check("t4_old_code_fail", 32'(bus.fail_pulse), 32'h1);
        check("t4_old_code_status", 32'(bus.status), 32'h1);
        key4(16'h9876);
        do_enter();
        check("t4_new_code", 32'(bus.status), 32'h2);
        check("t4_new_attempts", 32'(bus.attempts), 32'h0);

        // 5: strobe priority and reset mid-lockout
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        check("t5_reset_status", 32'(bus.status), 32'h1);
        key4(16'h1234);
        bus.digit_valid = 1'b1;
        bus.digit       = 4'd5;
        bus.enter       = 1'b1;
        tick();
        bus.digit_valid = 1'b0;
        bus.enter       = 1'b0;
        check("t5_enter_wins", 32'(bus.status), 32'h2);
        key4(16'h9876);
        do_set();
        do_lock();
        for (int k = 0; k < 3; k++) begin
            key4(16'h0000);
            do_enter();
        end
        check("t5_lockout", 32'(bus.status), 32'h3);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("t5_async_status", 32'(bus.status), 32'h1);
        check("t5_async_attempts", 32'(bus.attempts), 32'h0);
        #1;
        rst_n = 1'b1;
        key4(16'h1234);
        do_enter();
        check("t5_default_code", 32'(bus.status), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
